// File: rtl/voice_allocator.sv
// Voice scheduler: key-on/off events to a pool of voices (idle first, then steal releasing/oldest).
// Latency 2 edges to gate (3 when stealing); key_ready drops for the whole event, one event in flight.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 6,
  parameter int AGE_W      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        key_valid,
  input  logic                        key_on,
  input  logic [KEY_W-1:0]            key_code,
  output logic                        key_ready,
  input  logic [NUM_VOICES-1:0]       voice_idle,
  output logic [NUM_VOICES-1:0]       voice_note_on,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_rst_n
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_KILL, ST_ASSIGN} state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic                        r_ready;
  logic                        r_ev_on;
  logic [KEY_W-1:0]            r_ev_code;
  logic [VW-1:0]               r_v;
  logic [VW-1:0]               w_tgt;
  logic [AGE_W-1:0]            r_age [NUM_VOICES];
  logic [NUM_VOICES-1:0]       r_note_on;
  logic [NUM_VOICES*KEY_W-1:0] r_key;
  logic [NUM_VOICES-1:0]       r_rst_n;

  logic             w_match_ok, w_free_ok, w_rel_ok, w_held_ok;
  logic [VW-1:0]    w_match_idx, w_free_idx, w_rel_idx, w_held_idx;
  logic [AGE_W-1:0] w_rel_age, w_held_age;

  // A voice still gated is never "free", even if its envelope reports idle.
  always_comb begin
    w_match_ok  = 1'b0;
    w_match_idx = '0;
    w_free_ok   = 1'b0;
    w_free_idx  = '0;
    w_rel_ok    = 1'b0;
    w_rel_idx   = '0;
    w_rel_age   = '0;
    w_held_ok   = 1'b0;
    w_held_idx  = '0;
    w_held_age  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!w_match_ok && r_note_on[i] && (r_key[i*KEY_W +: KEY_W] == r_ev_code)) begin
        w_match_ok  = 1'b1;
        w_match_idx = VW'(i);
      end
      if (!w_free_ok && voice_idle[i] && !r_note_on[i]) begin
        w_free_ok  = 1'b1;
        w_free_idx = VW'(i);
      end
      if (!r_note_on[i] && !voice_idle[i] && (!w_rel_ok || (r_age[i] > w_rel_age))) begin
        w_rel_ok  = 1'b1;
        w_rel_idx = VW'(i);
        w_rel_age = r_age[i];
      end
      if (r_note_on[i] && (!w_held_ok || (r_age[i] > w_held_age))) begin
        w_held_ok  = 1'b1;
        w_held_idx = VW'(i);
        w_held_age = r_age[i];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_tgt  = r_v;
    case (r_state)
      ST_IDLE: begin
        if (key_valid && r_ready) w_next = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (!r_ev_on) begin
          w_next = w_match_ok ? ST_ASSIGN : ST_IDLE;
          w_tgt  = w_match_idx;
        end else if (w_match_ok) begin
          w_next = ST_KILL;
          w_tgt  = w_match_idx;
        end else if (w_free_ok) begin
          w_next = ST_ASSIGN;
          w_tgt  = w_free_idx;
        end else if (w_rel_ok) begin
          w_next = ST_KILL;
          w_tgt  = w_rel_idx;
        end else begin
          w_next = ST_KILL;
          w_tgt  = w_held_idx;
        end
      end
      ST_KILL:   w_next = ST_ASSIGN;
      ST_ASSIGN: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b0;
      r_ev_on   <= 1'b0;
      r_ev_code <= '0;
      r_v       <= '0;
      r_note_on <= '0;
      r_key     <= '0;
      r_rst_n   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_IDLE);
      r_rst_n <= '1;
      case (r_state)
        ST_IDLE: begin
          if (key_valid && r_ready) begin
            r_ev_on   <= key_on;
            r_ev_code <= key_code;
          end
        end
        ST_SEARCH: begin
          r_v <= w_tgt;
          // Ages only move on key-on; voices that are fully idle stay at zero.
          if (r_ev_on) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (VW'(i) == w_tgt) begin
                r_age[i] <= '0;
              end else if (r_note_on[i] || !voice_idle[i]) begin
                if (r_age[i] != '1) r_age[i] <= r_age[i] + AGE_W'(1);
              end else begin
                r_age[i] <= '0;
              end
            end
          end
        end
        ST_KILL: begin
          r_note_on[r_v] <= 1'b0;
          r_rst_n[r_v]   <= 1'b0;
        end
        ST_ASSIGN: begin
          r_note_on[r_v] <= r_ev_on;
          if (r_ev_on) r_key[r_v*KEY_W +: KEY_W] <= r_ev_code;
        end
        default: ;
      endcase
    end
  end

  assign key_ready     = r_ready;
  assign voice_note_on = r_note_on;
  assign voice_key     = r_key;
  assign voice_rst_n   = r_rst_n;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: event-timeline model compared every cycle, plus literal spot checks.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int KW = 6;
  localparam int AW = 8;

  logic             clk;
  logic             reset;
  logic             key_valid;
  logic             key_on;
  logic [KW-1:0]    key_code;
  logic             key_ready;
  logic [NV-1:0]    voice_idle;
  logic [NV-1:0]    voice_note_on;
  logic [NV*KW-1:0] voice_key;
  logic [NV-1:0]    voice_rst_n;

  voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .AGE_W(AW)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_on(key_on),
    .key_code(key_code), .key_ready(key_ready), .voice_idle(voice_idle),
    .voice_note_on(voice_note_on), .voice_key(voice_key), .voice_rst_n(voice_rst_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: voices as plain arrays; an event is a timeline of edges after acceptance.
  bit          m_started = 0;
  bit          m_note [NV];
  int          m_key  [NV];
  int          m_age  [NV];
  bit          m_ready;
  bit [NV-1:0] m_rst_n;
  int          m_edges;     // edges since acceptance, 0 = no event in flight
  bit          m_on;
  int          m_code;
  int          m_v;
  bit          m_steal;

  // Returns 0 = drop, 1 = direct assign, 2 = steal/retrigger; target in v.
  function automatic int policy(input bit on, input int code, input logic [NV-1:0] idle, output int v);
    int best;
    v = -1;
    for (int i = 0; i < NV; i++)
      if (v < 0 && m_note[i] && m_key[i] == code) v = i;
    if (!on) return (v < 0) ? 0 : 1;
    if (v >= 0) return 2;
    for (int i = 0; i < NV; i++)
      if (v < 0 && idle[i] && !m_note[i]) v = i;
    if (v >= 0) return 1;
    best = -1;
    for (int i = 0; i < NV; i++)
      if (!m_note[i] && !idle[i] && m_age[i] > best) begin best = m_age[i]; v = i; end
    if (v >= 0) return 2;
    for (int i = 0; i < NV; i++)
      if (m_note[i] && m_age[i] > best) begin best = m_age[i]; v = i; end
    return 2;
  endfunction

  always @(posedge clk) begin
    int act;
    m_started = 1;
    if (!reset) begin
      for (int i = 0; i < NV; i++) begin m_note[i] = 0; m_key[i] = 0; m_age[i] = 0; end
      m_ready = 0;
      m_rst_n = '0;
      m_edges = 0;
    end else begin
      m_rst_n = '1;
      if (m_edges == 0) begin
        if (m_ready && key_valid) begin
          m_on = key_on; m_code = int'(key_code); m_edges = 1;
        end
      end else if (m_edges == 1) begin
        act = policy(m_on, m_code, voice_idle, m_v);
        m_steal = (act == 2);
        if (m_on)
          for (int i = 0; i < NV; i++)
            if (i == m_v) m_age[i] = 0;
            else if (m_note[i] || !voice_idle[i]) m_age[i] = (m_age[i] < 255) ? m_age[i] + 1 : 255;
            else m_age[i] = 0;
        m_edges = (act == 0) ? 0 : 2;
      end else if (m_edges == 2 && m_steal) begin
        m_note[m_v] = 0;
        m_rst_n[m_v] = 1'b0;
        m_steal = 0;
      end else begin
        m_note[m_v] = m_on;
        if (m_on) m_key[m_v] = m_code;
        m_edges = 0;
      end
      m_ready = (m_edges == 0);
    end
  end

  // Compare process: every cycle once the model has seen an edge.
  always @(negedge clk) begin
    logic [NV-1:0]    e_note;
    logic [NV*KW-1:0] e_key;
    if (m_started) begin
      for (int i = 0; i < NV; i++) begin
        e_note[i] = m_note[i];
        e_key[i*KW +: KW] = KW'(m_key[i]);
      end
      chk("cyc_key_ready", 64'(key_ready), 64'(m_ready));
      chk("cyc_note_on", 64'(voice_note_on), 64'(e_note));
      chk("cyc_voice_key", 64'(voice_key), 64'(e_key));
      chk("cyc_rst_n", 64'(voice_rst_n), 64'(m_rst_n));
    end
  end

  logic [NV-1:0] obs_note  [4];
  logic [NV-1:0] obs_rst   [4];
  logic          obs_ready [4];

  // Enter and leave on a negedge; obs_*[k] is the DUT state after edge E(k).
  task automatic send(input bit on, input int code);
    int t = 0;
    while (key_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) chk("ready_timeout", 64'(key_ready), 64'd1);
    key_valid = 1'b1;
    key_on    = on;
    key_code  = KW'(code);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) key_valid = 1'b0;
      obs_note[k]  = voice_note_on;
      obs_rst[k]   = voice_rst_n;
      obs_ready[k] = key_ready;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; key_valid = 1'b0; key_on = 1'b0; key_code = '0; voice_idle = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_note_on", 64'(voice_note_on), 64'h0);
    chk("rst_voice_key", 64'(voice_key), 64'h0);
    chk("rst_rst_n", 64'(voice_rst_n), 64'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", 64'(key_ready), 64'd1);
    chk("rel_rst_n", 64'(voice_rst_n), 64'hF);

    // Fill the pool: idle voices taken lowest index first.
    send(1, 10);
    chk("on10_ready_e0", 64'(obs_ready[0]), 64'd0);
    chk("on10_note_e1", 64'(obs_note[1]), 64'h0);
    chk("on10_note_e2", 64'(obs_note[2]), 64'h1);
    chk("on10_ready_e2", 64'(obs_ready[2]), 64'd1);
    send(1, 12);
    send(1, 14);
    send(1, 16);
    chk("fill_note", 64'(voice_note_on), 64'hF);
    chk("fill_key", 64'(voice_key), 64'({6'd16, 6'd14, 6'd12, 6'd10}));

    voice_idle = 4'b0000;
    send(0, 12);
    chk("off12_note_e2", 64'(obs_note[2]), 64'hD);
    chk("off12_key1", 64'(voice_key[11:6]), 64'd12);
    send(0, 30);
    chk("off30_ready_e1", 64'(obs_ready[1]), 64'd1);
    chk("off30_note", 64'(obs_note[1]), 64'hD);

    // Releasing voice 1 is reclaimed; then the oldest held voice (0) is stolen.
    send(1, 12);
    chk("on12_rst_e2", 64'(obs_rst[2]), 64'hD);
    send(1, 20);
    chk("steal_rst_e1", 64'(obs_rst[1]), 64'hF);
    chk("steal_rst_e2", 64'(obs_rst[2]), 64'hE);
    chk("steal_rst_e3", 64'(obs_rst[3]), 64'hF);
    chk("steal_note_e2", 64'(obs_note[2]), 64'hE);
    chk("steal_note_e3", 64'(obs_note[3]), 64'hF);
    chk("steal_key", 64'(voice_key), 64'({6'd16, 6'd14, 6'd12, 6'd20}));

    // Voice 0 is youngest but releasing: it beats the oldest held voice 2.
    send(0, 20);
    send(1, 25);
    chk("prefrel_rst_e2", 64'(obs_rst[2]), 64'hE);
    chk("prefrel_key", 64'(voice_key), 64'({6'd16, 6'd14, 6'd12, 6'd25}));

    send(1, 14);
    chk("retrig_rst_e2", 64'(obs_rst[2]), 64'hB);
    chk("retrig_note_e2", 64'(obs_note[2]), 64'hB);
    chk("retrig_note_e3", 64'(obs_note[3]), 64'hF);
    chk("retrig_key", 64'(voice_key), 64'({6'd16, 6'd14, 6'd12, 6'd25}));

    // Reset lands on the SEARCH edge of a new event.
    key_valid = 1'b1; key_on = 1'b1; key_code = 6'd40;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_note", 64'(voice_note_on), 64'h0);
    chk("midrst_key", 64'(voice_key), 64'h0);
    chk("midrst_rst_n", 64'(voice_rst_n), 64'h0);
    chk("midrst_ready", 64'(key_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rel_ready", 64'(key_ready), 64'd1);
    chk("midrst_rel_note", 64'(voice_note_on), 64'h0);
    voice_idle = 4'b1111;
    send(1, 33);
    chk("post_note_e2", 64'(obs_note[2]), 64'h1);
    chk("post_key0", 64'(voice_key), 64'd33);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler that shares a fixed pool of envelope-generator voices among incoming keyboard note events. It accepts key-on and key-off events over a valid/ready handshake and assigns each key-on to a voice. Assignment prefers an idle voice; otherwise it steals a releasing voice or the oldest held voice. It drives each voice's `note_on`, key code and active-low voice reset. It sits between the keyboard decoder and the array of envelope/oscillator voices.

## Interface
- `NUM_VOICES`, default 4: number of voices in the pool (2–8).
- `KEY_W`, default 6: key-code width.
- `AGE_W`, default 8: width of each per-voice age counter.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `key_valid`  in  1  key event present.
- `key_on`  in  1  1 = press, 0 = release; qualified by `key_valid`.
- `key_code`  in  KEY_W  key number.
- `key_ready`  out  1  allocator can accept an event.
- `voice_idle`  in  NUM_VOICES  per-voice flag from the envelopes: 1 = envelope in its start state with amplitude 0.
- `voice_note_on`  out  NUM_VOICES  gate to each envelope.
- `voice_key`  out  NUM_VOICES*KEY_W  key code per voice; voice v occupies bits [v*KEY_W +: KEY_W].
- `voice_rst_n`  out  NUM_VOICES  active-low reset to each voice.

## Operation
- Handshake: an event is accepted on a rising edge where `key_valid && key_ready`. `key_ready` is 1 only in state IDLE. Inputs are latched at acceptance.
- State IDLE: waits for an event. On acceptance, go to SEARCH.
- State SEARCH: one cycle. It selects the target voice `v` and picks the next state.
  - Key-off:
    - `v` is the voice with `voice_note_on=1` and `voice_key==key_code`. Go to ASSIGN.
    - If there is no match, the event is dropped. Go to IDLE.
  - Key-on, taking the first rule that applies:
    1. A held voice with the same key exists: it is retriggered. Go to KILL.
    2. Lowest-index voice with `voice_idle=1`. Go to ASSIGN.
    3. Releasing voice (`note_on=0`, `idle=0`) with the largest age. Go to KILL.
    4. Held voice with the largest age. Go to KILL.
  - Age ties go to the lowest index.
- State KILL: one cycle. Drives `voice_note_on[v]=0` and `voice_rst_n[v]=0`. Go to ASSIGN.
- State ASSIGN: one cycle, then go to IDLE.
  - Key-on: `voice_key[v]=key_code`, `voice_note_on[v]=1`, `age[v]=0`.
  - Key-off: `voice_note_on[v]=0`, with `voice_key[v]` unchanged.
- Ages:
  - On each accepted key-on, every voice other than `v` with `note_on=1` or `idle=0` increments its age, saturating at 2^AGE_W−1.
  - Idle voices hold their age at 0.
- Voices other than `v` are never modified by an event.

## Timing
- All outputs are registered.
- Reset (`reset=0` at an edge):
  - state becomes IDLE, `key_ready=0`, `voice_note_on=0`, `voice_key=0`, ages = 0.
  - `voice_rst_n` is all 0 while reset is held.
  - On the first edge with `reset=1`: `key_ready=1` and `voice_rst_n` all 1.
  - Reset mid-operation aborts the event in flight. No partial assignment survives.
- Key-on into an idle voice, accepted at edge E0:
  - `key_ready=0` after E0.
  - `voice_note_on[v]` and `voice_key[v]` update after E2.
  - `key_ready=1` after E2.
- Steal or retrigger:
  - `voice_rst_n[v]=0` for exactly the cycle between E2 and E3.
  - `voice_note_on[v]=1` after E3.
  - `key_ready=1` after E3.
- Key-off: `voice_note_on[v]` falls after E2.
- Dropped key-off: `key_ready=1` after E1.
- Back-to-back events: the next event can be accepted on the first edge at which `key_ready=1`. Maximum throughput is one event per 3 cycles (4 for steals).
- `voice_idle` is sampled only during SEARCH.

## Test plan
- Reset: hold `reset=0` for 3 cycles, then release.
  - Required: all `note_on=0`, `voice_key=0`, `voice_rst_n=0` during reset.
  - After the first edge with `reset=1`: `key_ready=1`, `voice_rst_n=4'b1111`.
- Fill the pool: all `voice_idle=1`; send key-on 10, 12, 14, 16.
  - Required: voices 0–3 get keys 10, 12, 14, 16, with each `note_on` rising 2 edges after acceptance.
  - Ages afterwards: 3, 2, 1, 0.
- Release: key-off 12.
  - Required: `voice_note_on=4'b1101` 2 edges after acceptance, `voice_key[1]` still 12.
  - Key-off 30 (no match): no output change and `key_ready` back after 1 edge.
- Steal the oldest: pool full of held notes 10, 12, 14, 16 (`idle=0`); send key-on 20.
  - Required: `voice_rst_n[0]=0` for one cycle, then voice 0 is gated with key 20.
  - Voices 1–3 are untouched.
- Prefer releasing: voice 2 releasing (`note_on=0`, `idle=0`), others held and older; send key-on 25.
  - Required: voice 2 is stolen (rst pulse, then key 25), not the oldest held voice.
- Retrigger plus reset mid-event: key-on 14 while voice 2 holds 14.
  - Required: voice 2 receives an rst pulse and its `note_on` re-rises; no other voice is allocated.
  - Then assert `reset=0` during SEARCH of a new event: all outputs go to reset values and the event is lost.
